// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // RUN: requesting; DROP: waiting out a fetch killed by a redirect;
  // HOLD: a fetched instruction is parked while decode is stalled.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} skid register used while decode is stalled.
module fetch_hold_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            full_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            full_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  // Full flag: unload/clear win over load; payload only captured on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      if (clear_i || unload_i) begin
        full_q <= 1'b0;
      end else if (load_i) begin
        full_q <= 1'b1;
      end
      if (load_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage_hs.sv
// Instruction-fetch stage with valid/ack memory handshake, decode stall
// buffering, redirect handling and the IF/ID pipeline register.
module fetch_stage_hs
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pcF_q, pcF_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] pcPlus4F;

  logic            bufLoad, bufUnload, bufClear, bufFull;
  logic [31:0]     bufInstr;
  logic [XLEN-1:0] bufPc;

  logic            newValid;
  logic [31:0]     newInstr;
  logic [XLEN-1:0] newPc;

  // Natural XLEN-bit wrap gives the modulo-2^XLEN increment.
  assign pcPlus4F    = pcF_q + XLEN'(4);
  assign imem_addr_o = pcF_q;

  fetch_hold_buf #(
    .XLEN (XLEN)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (bufLoad),
    .unload_i (bufUnload),
    .clear_i  (bufClear),
    .instr_i  (imem_rdata_i),
    .pc_i     (pcF_q),
    .full_o   (bufFull),
    .instr_o  (bufInstr),
    .pc_o     (bufPc)
  );

  // Next-state, next-PC, hold-buffer control and the IF/ID candidate.
  always_comb begin
    state_d    = state_q;
    pcF_d      = pcF_q;
    target_d   = target_q;
    imem_req_o = 1'b0;
    bufLoad    = 1'b0;
    bufUnload  = 1'b0;
    bufClear   = 1'b0;
    newValid   = 1'b0;
    newInstr   = imem_rdata_i;
    newPc      = pcF_q;
    unique case (state_q)
      RUN: begin
        imem_req_o = 1'b1;
        if (pc_src_e) begin
          if (imem_rvalid_i) begin
            pcF_d = pc_target_e;  // acked data belongs to the wrong path
          end else begin
            target_d = pc_target_e;
            state_d  = DROP;
          end
        end else if (imem_rvalid_i) begin
          pcF_d = pcPlus4F;
          if (stall_d) begin
            bufLoad = 1'b1;
            state_d = HOLD;
          end else begin
            newValid = 1'b1;
          end
        end
      end
      DROP: begin
        // Address must stay on the killed fetch until it is acked.
        imem_req_o = 1'b1;
        if (pc_src_e) begin
          target_d = pc_target_e;
        end
        if (imem_rvalid_i) begin
          pcF_d   = pc_src_e ? pc_target_e : target_q;
          state_d = RUN;
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          bufClear = 1'b1;
          pcF_d    = pc_target_e;
          state_d  = RUN;
        end else if (!stall_d) begin
          bufUnload = bufFull;
          newValid  = bufFull;
          newInstr  = bufInstr;
          newPc     = bufPc;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Fetch FSM state, fetch PC and latched redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      pcF_q    <= RESET_PC;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pcF_q    <= pcF_d;
      target_q <= target_d;
    end
  end

  // IF/ID register: flush beats stall beats new instruction beats bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (stall_d) begin
      valid_d <= valid_d;
    end else if (newValid) begin
      instr_d    <= newInstr;
      pc_d       <= newPc;
      pc_plus4_d <= newPc + XLEN'(4);
      valid_d    <= 1'b1;
    end else begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end
  end

endmodule
